// File: rtl/y86_alu_pkg.sv
// Shared y86 ALU types: operation encoding, word width and condition-code record.
// Used by alu_arbiter and by any stage that instantiates alu_core_64.
package y86_alu_pkg;

    localparam int WORD_W = 64;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_XOR = 2'd3
    } alu_op_t;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

endpackage

// File: rtl/alu_core_64.sv
// Combinational y86 ALU datapath: add (B+A), sub (B-A), and, xor, with signed overflow.
// Pure logic with no state, so other pipeline stages can share it.
module alu_core_64
    import y86_alu_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             of
);

    logic [WIDTH-1:0] sum_y;
    logic [WIDTH-1:0] diff_y;
    logic [WIDTH-1:0] and_y;
    logic [WIDTH-1:0] xor_y;
    logic             add_of;
    logic             sub_of;

    // y86 subq rA,rB computes rB - rA, so B is the minuend.
    assign sum_y  = b + a;
    assign diff_y = b - a;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_logic_unit
        assign and_y[gi] = a[gi] & b[gi];
        assign xor_y[gi] = a[gi] ^ b[gi];
    end

    assign add_of = (a[WIDTH-1] == b[WIDTH-1]) && (sum_y[WIDTH-1] != a[WIDTH-1]);
    assign sub_of = (a[WIDTH-1] != b[WIDTH-1]) && (diff_y[WIDTH-1] != b[WIDTH-1]);

    always_comb begin
        y  = '0;
        of = 1'b0;
        case (alu_op_t'(op))
            ALU_ADD: begin
                y  = sum_y;
                of = add_of;
            end
            ALU_SUB: begin
                y  = diff_y;
                of = sub_of;
            end
            ALU_AND: y = and_y;
            ALU_XOR: y = xor_y;
            default: begin
                y  = '0;
                of = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one y86 ALU between two requesters, with a one-entry
// result buffer and the ZF/SF/OF register (present only when ALU_ARB_CC_EN is defined).
module alu_arbiter
    import y86_alu_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_set_cc,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_set_cc,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_of,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of
);

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

    buf_state_t       state_reg;
    logic             last_grant_reg;
    logic             can_accept;
    logic             grant0;
    logic             grant1;
    logic             grant_any;
    logic             win_id;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] alu_y;
    logic             alu_of;

    // A full buffer can still accept when the consumer drains it in the same cycle.
    assign can_accept = rst_n && ((state_reg == BUF_EMPTY) || rsp_ready);

    // On a tie the requester that did not win last time goes first.
    assign grant0    = can_accept && req0_valid && (!req1_valid || last_grant_reg);
    assign grant1    = can_accept && req1_valid && (!req0_valid || !last_grant_reg);
    assign grant_any = grant0 || grant1;
    assign win_id    = grant1;

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign sel_op = win_id ? req1_op : req0_op;
    assign sel_a  = win_id ? req1_a  : req0_a;
    assign sel_b  = win_id ? req1_b  : req0_b;

    alu_core_64 #(
        .WIDTH (WIDTH)
    ) u_alu (
        .op (sel_op),
        .a  (sel_a),
        .b  (sel_b),
        .y  (alu_y),
        .of (alu_of)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= BUF_EMPTY;
            rsp_valid      <= 1'b0;
            rsp_y          <= '0;
            rsp_of         <= 1'b0;
            rsp_id         <= 1'b0;
            last_grant_reg <= 1'b1;
        end else begin
            case (state_reg)
                BUF_EMPTY: begin
                    if (grant_any) begin
                        state_reg <= BUF_FULL;
                        rsp_valid <= 1'b1;
                    end
                end
                BUF_FULL: begin
                    if (grant_any) begin
                        state_reg <= BUF_FULL;
                        rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        state_reg <= BUF_EMPTY;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= BUF_EMPTY;
                    rsp_valid <= 1'b0;
                end
            endcase
            if (grant_any) begin
                rsp_y          <= alu_y;
                rsp_of         <= alu_of;
                rsp_id         <= win_id;
                last_grant_reg <= win_id;
            end
        end
    end

`ifdef ALU_ARB_CC_EN
    cc_t  cc_reg;
    logic sel_set_cc;

    assign sel_set_cc = win_id ? req1_set_cc : req0_set_cc;

    // Flags come straight from the ALU output so they land on the same edge as rsp_y.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cc_reg <= '{zf: 1'b1, sf: 1'b0, of: 1'b0};
        end else if (grant_any && sel_set_cc) begin
            cc_reg <= '{zf: (alu_y == '0), sf: alu_y[WIDTH-1], of: alu_of};
        end
    end

    assign cc_zf = cc_reg.zf;
    assign cc_sf = cc_reg.sf;
    assign cc_of = cc_reg.of;
`else
    logic unused_set_cc;

    assign unused_set_cc = req0_set_cc ^ req1_set_cc;
    assign cc_zf = 1'b0;
    assign cc_sf = 1'b0;
    assign cc_of = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: reference model (result queue, round-robin winner,
// wide-arithmetic ALU) compared every cycle, plus directed literal checks.
module tb_alu_arbiter;
    import y86_alu_pkg::*;

    localparam int W = WORD_W;
`ifdef ALU_ARB_CC_EN
    localparam bit CC_EN = 1'b1;
`else
    localparam bit CC_EN = 1'b0;
`endif

    localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MINN = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] NEG1 = {W{1'b1}};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         v0, v1, rdy0, rdy1, sc0, sc1;
    logic [1:0]   op0, op1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_of;
    logic [W-1:0] rsp_y;
    logic         zf, sf, of;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (v0),
        .req0_ready  (rdy0),
        .req0_op     (op0),
        .req0_a      (a0),
        .req0_b      (b0),
        .req0_set_cc (sc0),
        .req1_valid  (v1),
        .req1_ready  (rdy1),
        .req1_op     (op1),
        .req1_a      (a1),
        .req1_b      (b1),
        .req1_set_cc (sc1),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_y       (rsp_y),
        .rsp_of      (rsp_of),
        .cc_zf       (zf),
        .cc_sf       (sf),
        .cc_of       (of)
    );

    typedef struct {
        logic         id;
        logic [W-1:0] y;
        logic         ovf;
    } res_t;

    res_t q[$];
    logic m_last;
    logic m_zf, m_sf, m_of;
    logic m_g0, m_g1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic ccx(input logic v);
        return CC_EN ? v : 1'b0;
    endfunction

    // Reference ALU: exact (W+1)-bit arithmetic, overflow when the result leaves W-bit range.
    function automatic res_t alu_ref(input logic id, input logic [1:0] op,
                                     input logic [W-1:0] a, input logic [W-1:0] b);
        res_t r;
        logic [W:0] wide;
        r.id = id;
        r.ovf = 1'b0;
        wide = '0;
        case (op)
            2'd0: wide = {b[W-1], b} + {a[W-1], a};
            2'd1: wide = {b[W-1], b} - {a[W-1], a};
            2'd2: wide = {1'b0, a & b};
            default: wide = {1'b0, a ^ b};
        endcase
        r.y = wide[W-1:0];
        if (op < 2'd2) r.ovf = (wide[W] != wide[W-1]);
        return r;
    endfunction

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0: v = '0;
            1: v = MAXP;
            2: v = MINN;
            3: v = NEG1;
            4: v = W'($urandom_range(0, 3));
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    // One clock: compare everything against the model, then advance the model at the edge.
    task automatic step(input logic rr);
        logic can, any, win;
        res_t r;
        rsp_ready = rr;
        #1;
        can = rst_n && (q.size() == 0 || rr);
        any = can && (v0 || v1);
        win = (v0 && v1) ? ~m_last : v1;
        m_g0 = any && !win;
        m_g1 = any && win;
        chk1("req0_ready", rdy0, m_g0);
        chk1("req1_ready", rdy1, m_g1);
        chk1("rsp_valid", rsp_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("rsp_y", rsp_y, q[0].y);
            chk1("rsp_of", rsp_of, q[0].ovf);
            chk1("rsp_id", rsp_id, q[0].id);
        end
        chk1("cc_zf", zf, ccx(m_zf));
        chk1("cc_sf", sf, ccx(m_sf));
        chk1("cc_of", of, ccx(m_of));
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            m_last = 1'b1;
            m_zf = 1'b1;
            m_sf = 1'b0;
            m_of = 1'b0;
        end else begin
            if (q.size() != 0 && rr) void'(q.pop_front());
            if (any) begin
                r = win ? alu_ref(1'b1, op1, a1, b1) : alu_ref(1'b0, op0, a0, b0);
                q.push_back(r);
                m_last = win;
                if (win ? sc1 : sc0) begin
                    m_zf = (r.y == '0);
                    m_sf = r.y[W-1];
                    m_of = r.ovf;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] held_y;
        logic         held_id;
        logic         held_zf, held_sf, held_of;

        m_last = 1'b1; m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
        m_g0 = 1'b0; m_g1 = 1'b0;
        rst_n = 1'b0; rsp_ready = 1'b1;
        v0 = 1'b0; v1 = 1'b0; op0 = 2'd0; op1 = 2'd0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; sc0 = 1'b0; sc1 = 1'b0;
        @(negedge clk);
        step(1'b1);
        step(1'b1);
        chk1("reset rsp_valid", rsp_valid, 1'b0);
        chk("reset rsp_y", rsp_y, '0);
        chk1("reset rsp_id", rsp_id, 1'b0);
        chk1("reset zf", zf, ccx(1'b1));

        // req0 add 1 + -1
        rst_n = 1'b1;
        v0 = 1'b1; op0 = 2'd0; a0 = W'(1); b0 = NEG1; sc0 = 1'b1;
        step(1'b1);
        v0 = 1'b0;
        chk("add0 y", rsp_y, '0);
        chk1("add0 of", rsp_of, 1'b0);
        chk1("add0 id", rsp_id, 1'b0);
        chk1("add0 zf", zf, ccx(1'b1));

        // req1 add max+max, no CC update
        v1 = 1'b1; op1 = 2'd0; a1 = MAXP; b1 = MAXP; sc1 = 1'b0;
        step(1'b1);
        v1 = 1'b0;
        chk("addmax y", rsp_y, NEG1 - W'(1));
        chk1("addmax of", rsp_of, 1'b1);
        chk1("addmax id", rsp_id, 1'b1);
        chk1("addmax zf held", zf, ccx(1'b1));
        chk1("addmax of held", of, 1'b0);

        // req0 sub: MIN - 1
        v0 = 1'b1; op0 = 2'd1; a0 = W'(1); b0 = MINN; sc0 = 1'b1;
        step(1'b1);
        chk("sub y", rsp_y, MAXP);
        chk1("sub of", rsp_of, 1'b1);
        chk1("sub cc_of", of, ccx(1'b1));
        chk1("sub cc_zf", zf, 1'b0);
        chk1("sub cc_sf", sf, 1'b0);

        // req0 and
        op0 = 2'd2; a0 = MAXP; b0 = MINN;
        step(1'b1);
        v0 = 1'b0;
        chk("and y", rsp_y, '0);
        chk1("and of", rsp_of, 1'b0);
        chk1("and zf", zf, ccx(1'b1));
        chk1("and cc_of", of, 1'b0);

        // Fresh reset, then both valid: grants alternate from requester 0
        rst_n = 1'b0;
        step(1'b1);
        rst_n = 1'b1;
        v0 = 1'b1; op0 = 2'd0; a0 = W'(5); b0 = W'(7); sc0 = 1'b1;
        v1 = 1'b1; op1 = 2'd1; a1 = W'(9); b1 = W'(3); sc1 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step(1'b1);
            chk1("alternate id", rsp_id, k[0]);
            chk1("alternate valid", rsp_valid, 1'b1);
        end

        // Stall with both requesters waiting
        held_y = rsp_y; held_id = rsp_id;
        held_zf = zf; held_sf = sf; held_of = of;
        for (int k = 0; k < 3; k++) begin
            step(1'b0);
            chk("stall y", rsp_y, held_y);
            chk1("stall id", rsp_id, held_id);
            chk1("stall zf", zf, held_zf);
            chk1("stall sf", sf, held_sf);
            chk1("stall of", of, held_of);
        end
        step(1'b1);
        chk1("refill valid", rsp_valid, 1'b1);
        chk1("refill id", rsp_id, ~held_id);

        // Reset while full discards the result
        rst_n = 1'b0;
        step(1'b0);
        chk1("rst full valid", rsp_valid, 1'b0);
        chk1("rst full zf", zf, ccx(1'b1));
        chk1("rst full sf", sf, 1'b0);
        chk1("rst full of", of, 1'b0);
        rst_n = 1'b1; v0 = 1'b0; v1 = 1'b0;
        step(1'b1);
        step(1'b1);
        chk1("post rst valid", rsp_valid, 1'b0);

        // Randomized traffic with held requests until granted
        m_g0 = 1'b0; m_g1 = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!v0 || m_g0) begin
                v0 = ($urandom_range(0, 2) != 0);
                op0 = 2'($urandom_range(0, 3));
                a0 = pick(); b0 = pick();
                sc0 = 1'($urandom_range(0, 1));
            end
            if (!v1 || m_g1) begin
                v1 = ($urandom_range(0, 2) != 0);
                op1 = 2'($urandom_range(0, 3));
                a1 = pick(); b1 = pick();
                sc1 = 1'($urandom_range(0, 1));
            end
            rst_n = ($urandom_range(0, 99) != 0);
            step($urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
